ray_tag_dispatcher: RTL and testbench

Front end of the divider array: accepts normalize jobs (ray direction plus length) from the ray pipeline and stamps each one with the next tag in the system tag sequence. It then issues the job to one of DIV_COUNT divider lanes in round-robin order, skipping lanes that are busy or whose collector lane is full. It also caps the number of in-flight jobs so that tags never alias in the downstream tag-ordered collector, which returns one retire pulse per in-order result.

---
 rtl/ray_tag_dispatcher.sv | 142 ++++++++++++++
 tb/tb_ray_tag_dispatcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_tag_dispatcher.sv
// ray_tag_dispatcher
// Front end of the divider array. Accepts normalize jobs from the ray
// pipeline and stamps each one with the next tag of the system tag sequence
// (1, 3, 7, ..., all-ones, 1, ...). Each job is issued to one divider lane,
// chosen round-robin among the lanes that are neither busy nor backed up in
// the collector. The number of outstanding jobs is capped so that tags never
// alias in the tag-ordered collector, which retires one job per retire pulse.
//
// Handshake: a job transfers on a rising clk edge where in_valid && in_ready.
// in_ready is combinational, does not look at in_valid, and is high when the
// in-flight count is below MAX_INFLIGHT and at least one lane is eligible.
// Downstream there is no back-pressure on the strobe: div_valid_out is a
// one-cycle, one-hot pulse, and each lane's data/tag stay put until that
// lane is issued to again.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   in_valid        job offered
//   in_data         job payload (direction + length)
//   in_ready        job accepted this cycle when in_valid && in_ready
//   div_busy_in     per-lane divider busy
//   lane_full_in    per-lane collector FIFO full
//   retire_in       one pulse per in-order result from the collector
//   div_valid_out   one-hot issue strobe
//   div_data_out    per-lane payload (lane i at [i*DATA_W +: DATA_W])
//   div_tag_out     per-lane tag (lane i at [i*TAG_SIZE +: TAG_SIZE])
//   inflight_out    outstanding job count
//   idle_out        nothing outstanding and nothing being issued

`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module ray_tag_dispatcher #(
  parameter int DIV_COUNT    = 16,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int DATA_W       = 128,
  parameter int MAX_INFLIGHT = TAG_SIZE,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1),
  localparam int PW          = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [DIV_COUNT-1:0]          div_busy_in,
  input  logic [DIV_COUNT-1:0]          lane_full_in,
  input  logic                          retire_in,
  output logic [DIV_COUNT-1:0]          div_valid_out,
  output logic [DIV_COUNT*DATA_W-1:0]   div_data_out,
  output logic [DIV_COUNT*TAG_SIZE-1:0] div_tag_out,
  output logic [IW-1:0]                 inflight_out,
  output logic                          idle_out
);

  logic [DIV_COUNT-1:0] eligible;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;
  logic [PW-1:0]        chosen;
  logic                 found;
  logic [TAG_SIZE-1:0]  cur_tag;
  logic [TAG_SIZE-1:0]  next_tag;
  logic [IW-1:0]        inflight;
  logic [IW-1:0]        inflight_next;
  logic                 accept;
  logic                 retire_eff;
  int                   sel_idx;
  logic [PW-1:0]        sel_lane;

  assign eligible = ~div_busy_in & ~lane_full_in;

  // Scan from the farthest lane back toward rr_ptr so the last hit, i.e. the
  // first eligible lane at or after rr_ptr, is the one that sticks.
  always_comb begin
    chosen   = '0;
    found    = 1'b0;
    sel_idx  = 0;
    sel_lane = '0;
    for (int k = DIV_COUNT - 1; k >= 0; k--) begin
      sel_idx = int'(rr_ptr) + k;
      if (sel_idx >= DIV_COUNT) sel_idx = sel_idx - DIV_COUNT;
      sel_lane = PW'(sel_idx);
      if (eligible[sel_lane]) begin
        chosen = sel_lane;
        found  = 1'b1;
      end
    end
  end

  assign in_ready   = (inflight < IW'(MAX_INFLIGHT)) && found;
  assign accept     = in_valid && in_ready;
  // A retire with nothing outstanding is spurious and is dropped.
  assign retire_eff = retire_in && (inflight != '0);

  assign rr_next  = (chosen == PW'(DIV_COUNT - 1)) ? '0 : chosen + PW'(1);
  assign next_tag = (&cur_tag) ? TAG_SIZE'(1) : {cur_tag[TAG_SIZE-2:0], 1'b1};

  always_comb begin
    inflight_next = inflight;
    case ({accept, retire_eff})
      2'b10:   inflight_next = inflight + IW'(1);
      2'b01:   inflight_next = inflight - IW'(1);
      default: inflight_next = inflight;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      cur_tag  <= TAG_SIZE'(1);
      inflight <= '0;
      idle_out <= 1'b1;
    end else begin
      inflight <= inflight_next;
      idle_out <= (inflight_next == '0) && !accept;
      if (accept) begin
        rr_ptr  <= rr_next;
        cur_tag <= next_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_valid_out <= '0;
      div_data_out  <= '0;
      div_tag_out   <= '0;
    end else begin
      div_valid_out <= accept ? (DIV_COUNT'(1) << chosen) : '0;
      for (int i = 0; i < DIV_COUNT; i++) begin
        if (accept && (chosen == PW'(i))) begin
          div_data_out[i*DATA_W +: DATA_W]   <= in_data;
          div_tag_out[i*TAG_SIZE +: TAG_SIZE] <= cur_tag;
        end
      end
    end
  end

  assign inflight_out = inflight;

endmodule

// File: tb/tb_ray_tag_dispatcher.sv
// Directed bench for ray_tag_dispatcher. A main instance (16 lanes, 8-bit
// tags, cap 8) covers issue order, lane skipping, the in-flight cap, retire
// handling, lane-full stalls and async reset. A small instance (4 lanes,
// 4-bit tags, cap 4) covers the tag wrap under continuous issue/retire.
module tb_ray_tag_dispatcher;

  logic clk;
  logic reset;

  // main instance
  logic          in_valid;
  logic [127:0]  in_data;
  logic          in_ready;
  logic [15:0]   busy;
  logic [15:0]   full;
  logic          retire;
  logic [15:0]   dv;
  logic [2047:0] dd;
  logic [127:0]  dt;
  logic [3:0]    infl;
  logic          idle;

  // wrap-test instance
  logic          v4;
  logic [7:0]    d4;
  logic          r4;
  logic [3:0]    busy4;
  logic [3:0]    full4;
  logic          ret4;
  logic [3:0]    dv4;
  logic [31:0]   dd4;
  logic [15:0]   dt4;
  logic [2:0]    infl4;
  logic          idle4;

  int n_vec;
  int n_err;

  ray_tag_dispatcher #(
    .DIV_COUNT(16), .TAG_SIZE(8), .DATA_W(128), .MAX_INFLIGHT(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div_busy_in(busy), .lane_full_in(full), .retire_in(retire),
    .div_valid_out(dv), .div_data_out(dd), .div_tag_out(dt),
    .inflight_out(infl), .idle_out(idle)
  );

  ray_tag_dispatcher #(
    .DIV_COUNT(4), .TAG_SIZE(4), .DATA_W(8), .MAX_INFLIGHT(4)
  ) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(v4), .in_data(d4), .in_ready(r4),
    .div_busy_in(busy4), .lane_full_in(full4), .retire_in(ret4),
    .div_valid_out(dv4), .div_data_out(dd4), .div_tag_out(dt4),
    .inflight_out(infl4), .idle_out(idle4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_issue(input string tag, input int lane, input logic [7:0] etag,
                           input logic [127:0] edata);
    logic [15:0] oh;
    oh = 16'h1 << lane;
    chk({tag, ".valid"}, 128'(dv), 128'(oh));
    chk({tag, ".tag"}, 128'(dt[lane*8 +: 8]), 128'(etag));
    chk({tag, ".data"}, dd[lane*128 +: 128], edata);
  endtask

  task automatic exp_issue4(input string tag, input int lane, input logic [3:0] etag,
                            input logic [7:0] edata);
    logic [3:0] oh;
    oh = 4'h1 << lane;
    chk({tag, ".valid"}, 128'(dv4), 128'(oh));
    chk({tag, ".tag"}, 128'(dt4[lane*4 +: 4]), 128'(etag));
    chk({tag, ".data"}, 128'(dd4[lane*8 +: 8]), 128'(edata));
  endtask

  initial begin
    logic [7:0] tags5 [5];
    logic [3:0] seq4 [6];
    tags5 = '{8'h01, 8'h03, 8'h07, 8'h0f, 8'h1f};
    seq4  = '{4'h1, 4'h3, 4'h7, 4'hf, 4'h1, 4'h3};
    n_vec = 0;
    n_err = 0;

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; busy = '0; full = '0; retire = 1'b0;
    v4 = 1'b0; d4 = '0; busy4 = '0; full4 = '0; ret4 = 1'b0;

    // reset state
    #2;
    chk("rst.valid", 128'(dv), 128'(0));
    chk("rst.tag", dt, 128'(0));
    chk("rst.data_or", 128'(|dd), 128'(0));
    chk("rst.inflight", 128'(infl), 128'(0));
    chk("rst.idle", 128'(idle), 128'(1));
    chk("rst.ready", 128'(in_ready), 128'(1));
    chk("rst4.inflight", 128'(infl4), 128'(0));
    #10;
    reset = 1'b0;

    // five back-to-back jobs: lanes 0..4, tags 1,3,7,15,31
    in_valid = 1'b1;
    in_data  = 128'h100;
    #1;
    chk("b2b.ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_issue("b2b", i, tags5[i], 128'h100 + 128'(i));
      chk("b2b.inflight", 128'(infl), 128'(i + 1));
      in_data = 128'h100 + 128'(i + 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("gap.valid", 128'(dv), 128'(0));
    chk("gap.idle", 128'(idle), 128'(0));
    chk("gap.inflight", 128'(infl), 128'(5));

    // two retires bring inflight to 3, then accept+retire holds it at 3
    retire = 1'b1;
    cyc();
    chk("ret.inflight4", 128'(infl), 128'(4));
    cyc();
    chk("ret.inflight3", 128'(infl), 128'(3));
    in_valid = 1'b1;
    in_data  = 128'h200;
    cyc();
    exp_issue("accret", 5, 8'h3f, 128'h200);
    chk("accret.inflight", 128'(infl), 128'(3));
    retire = 1'b0;

    // fill to the cap: tags 127,255 then wrap to 1,3,7 on lanes 6..10
    begin
      logic [7:0] ftag [5];
      ftag = '{8'h7f, 8'hff, 8'h01, 8'h03, 8'h07};
      for (int j = 0; j < 5; j++) begin
        in_data = 128'h300 + 128'(j);
        cyc();
        exp_issue("fill", 6 + j, ftag[j], 128'h300 + 128'(j));
      end
    end
    chk("fill.inflight", 128'(infl), 128'(8));
    chk("fill.ready", 128'(in_ready), 128'(0));
    cyc();
    chk("cap.valid", 128'(dv), 128'(0));
    chk("cap.inflight", 128'(infl), 128'(8));
    retire = 1'b1;
    cyc();
    retire = 1'b0;
    chk("cap.ret_inflight", 128'(infl), 128'(7));
    chk("cap.ret_valid", 128'(dv), 128'(0));
    #1;
    chk("cap.ready_back", 128'(in_ready), 128'(1));
    in_data = 128'h400;
    cyc();
    exp_issue("cap.next", 11, 8'h0f, 128'h400);
    chk("cap.next_inflight", 128'(infl), 128'(8));
    in_valid = 1'b0;

    // drain to zero, then one spurious retire
    retire = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("drain.inflight", 128'(infl), 128'(0));
    cyc();
    chk("drain.sat", 128'(infl), 128'(0));
    chk("drain.idle", 128'(idle), 128'(1));
    retire = 1'b0;

    // reset, then busy-lane skip
    reset = 1'b1;
    #3;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 128'h500;
    cyc();
    exp_issue("skip.first", 0, 8'h01, 128'h500);
    busy    = 16'h0002;
    in_data = 128'h501;
    cyc();
    exp_issue("skip.busy", 2, 8'h03, 128'h501);
    busy    = 16'h0000;
    in_data = 128'h502;
    cyc();
    exp_issue("skip.rr3", 3, 8'h07, 128'h502);

    // every collector lane full: stall, tag holds
    full    = 16'hffff;
    in_data = 128'h600;
    #1;
    chk("full.ready", 128'(in_ready), 128'(0));
    cyc();
    chk("full.valid", 128'(dv), 128'(0));
    chk("full.inflight", 128'(infl), 128'(3));
    full = 16'hff7f;
    #1;
    chk("full.ready7", 128'(in_ready), 128'(1));
    cyc();
    exp_issue("full.lane7", 7, 8'h0f, 128'h600);
    full    = 16'h0000;
    in_data = 128'h601;
    cyc();
    exp_issue("full.lane8", 8, 8'h1f, 128'h601);

    // async reset mid-stream
    reset = 1'b1;
    #1;
    chk("arst.valid", 128'(dv), 128'(0));
    chk("arst.tag", dt, 128'(0));
    chk("arst.data_or", 128'(|dd), 128'(0));
    chk("arst.inflight", 128'(infl), 128'(0));
    chk("arst.idle", 128'(idle), 128'(1));
    reset   = 1'b0;
    in_data = 128'h700;
    cyc();
    exp_issue("arst.next", 0, 8'h01, 128'h700);
    in_valid = 1'b0;

    // 4-bit tag wrap with continuous issue and retire
    v4 = 1'b1;
    d4 = 8'h10;
    cyc();
    exp_issue4("wrap", 0, seq4[0], 8'h10);
    chk("wrap.inflight", 128'(infl4), 128'(1));
    ret4 = 1'b1;
    for (int k = 1; k < 6; k++) begin
      d4 = 8'h10 + 8'(k);
      cyc();
      exp_issue4("wrap", k % 4, seq4[k], 8'h10 + 8'(k));
      chk("wrap.inflight", 128'(infl4), 128'(1));
    end
    v4 = 1'b0;
    cyc();
    ret4 = 1'b0;
    chk("wrap.drain", 128'(infl4), 128'(0));
    chk("wrap.valid_off", 128'(dv4), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
